// File: rtl/axi_control_unit.sv
// Device end of a bus-and-tag channel: selection, one command, status and data bytes over AXI-Stream.
// Optional CU_ADDR_MASK_EN: masked address compare, echo of the address actually received.
module axi_control_unit #(
   parameter logic [7:0] DEVICE_ADDRESS = 8'h10,
   parameter logic [7:0] ADDR_MASK      = 8'hFF
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  a_bus_out,
   output logic [7:0]  a_bus_in,
   input  logic        a_operational_out,
   input  logic        a_select_out,
   input  logic        a_hold_out,
   input  logic        a_address_out,
   input  logic        a_command_out,
   input  logic        a_service_out,
   input  logic        a_suppress_out,
   output logic        a_select_in,
   output logic        a_operational_in,
   output logic        a_address_in,
   output logic        a_status_in,
   output logic        a_service_in,
   output logic        a_request_in,
   output logic [15:0] cmd_tdata,
   output logic        cmd_tvalid,
   input  logic [7:0]  send_tdata,
   input  logic        send_tvalid,
   input  logic        send_tlast,
   output logic        send_tready,
   output logic [7:0]  recv_tdata,
   output logic        recv_tvalid,
   output logic        recv_tlast,
   input  logic        recv_tready,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR_IN, CMD_WAIT, STAT_INIT, INIT_ACK, WR_IDLE, WR_XFER, WR_ACK,
      RD_FETCH, RD_SVC, RD_ACK, STOP_WAIT, STAT_END, END_ACK, DESEL
   } state_t;

   state_t     state, state_nx;
   logic [5:0] tag_s1, tag_s2, tag_d;
   logic       op_s, sel_s, hold_s, addr_s, cmd_s, svc_s;
   logic       addr_rise, cmd_rise, addr_hit;
   logic [7:0] echo_addr, cmd_q, rd_q, recv_q;
   logic       match_q, sel_in_q, last_q;
   logic       unused_suppress;

   assign unused_suppress = a_suppress_out;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tag_s1 <= '0;
         tag_s2 <= '0;
         tag_d  <= '0;
      end else begin
         tag_s1 <= {a_operational_out, a_select_out, a_hold_out,
                    a_address_out, a_command_out, a_service_out};
         tag_s2 <= tag_s1;
         tag_d  <= tag_s2;
      end
   end

   assign {op_s, sel_s, hold_s, addr_s, cmd_s, svc_s} = tag_s2;
   assign addr_rise = addr_s & ~tag_d[2];
   assign cmd_rise  = cmd_s  & ~tag_d[1];

`ifdef CU_ADDR_MASK_EN
   logic [7:0] addr_q;
   assign addr_hit  = (a_bus_out & ADDR_MASK) == (DEVICE_ADDRESS & ADDR_MASK);
   assign echo_addr = addr_q;
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         addr_q <= '0;
      else if (state == IDLE && addr_rise)
         addr_q <= a_bus_out;
   end
`else
   logic [7:0] unused_mask;
   assign unused_mask = ADDR_MASK;
   assign addr_hit    = (a_bus_out == DEVICE_ADDRESS);
   assign echo_addr   = DEVICE_ADDRESS;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         match_q    <= 1'b0;
         sel_in_q   <= 1'b0;
         cmd_q      <= '0;
         cmd_tdata  <= '0;
         cmd_tvalid <= 1'b0;
         rd_q       <= '0;
         last_q     <= 1'b0;
         recv_q     <= '0;
      end else begin
         state      <= state_nx;
         cmd_tvalid <= 1'b0;
         if (!op_s) begin
            match_q  <= 1'b0;
            sel_in_q <= 1'b0;
         end else begin
            // Not addressed to us: pass selection down the chain one cycle late.
            sel_in_q <= (state == IDLE) && !match_q && sel_s && hold_s;
            if (state == IDLE && addr_rise)
               match_q <= addr_hit;
            if (state == DESEL && !sel_s)
               match_q <= 1'b0;
            if (state == ADDR_IN && cmd_rise) begin
               cmd_q      <= a_bus_out;
               cmd_tdata  <= {echo_addr, a_bus_out};
               cmd_tvalid <= 1'b1;
            end
         end
         if (state == WR_IDLE && svc_s)
            recv_q <= a_bus_out;
         if (state == RD_FETCH && send_tvalid) begin
            rd_q   <= send_tdata;
            last_q <= send_tlast;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (match_q && sel_s && hold_s) state_nx = ADDR_IN;
         ADDR_IN:   if (cmd_rise) state_nx = CMD_WAIT;
         CMD_WAIT:  if (!cmd_s) state_nx = STAT_INIT;
         STAT_INIT: if (svc_s || cmd_s) state_nx = INIT_ACK;
         INIT_ACK:
            if (!svc_s && !cmd_s) begin
               if (cmd_q == 8'h00)  state_nx = DESEL;
               else if (cmd_q[0])   state_nx = WR_IDLE;
               else                 state_nx = RD_FETCH;
            end
         WR_IDLE:
            if (svc_s)              state_nx = WR_XFER;
            else if (cmd_s)         state_nx = STOP_WAIT;
         WR_XFER:   if (recv_tready) state_nx = WR_ACK;
         WR_ACK:    if (!svc_s) state_nx = WR_IDLE;
         RD_FETCH:  if (send_tvalid) state_nx = RD_SVC;
         RD_SVC:
            if (svc_s)              state_nx = RD_ACK;
            else if (cmd_s)         state_nx = STOP_WAIT;
         RD_ACK:    if (!svc_s) state_nx = last_q ? STAT_END : RD_FETCH;
         STOP_WAIT: if (!svc_s && !cmd_s) state_nx = STAT_END;
         STAT_END:  if (svc_s || cmd_s) state_nx = END_ACK;
         END_ACK:   if (!svc_s && !cmd_s) state_nx = DESEL;
         DESEL:     if (!sel_s) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
      if (!op_s)
         state_nx = IDLE;
   end

   always_comb begin
      a_select_in      = sel_in_q;
      a_operational_in = (state != IDLE);
      a_address_in     = (state == ADDR_IN);
      a_status_in      = (state == STAT_INIT) || (state == STAT_END);
      a_service_in     = (state == WR_IDLE) || (state == WR_XFER) || (state == RD_SVC);
      a_request_in     = 1'b0;
      send_tready      = (state == RD_FETCH) && send_tvalid;
      recv_tvalid      = (state == WR_XFER);
      recv_tdata       = (state == WR_XFER) ? recv_q : '0;
      recv_tlast       = 1'b0;
      busy             = match_q || (state != IDLE);
      case (state)
         ADDR_IN:   a_bus_in = echo_addr;
         STAT_INIT: a_bus_in = (cmd_q == 8'h00) ? 8'h0C : 8'h00;
         RD_SVC:    a_bus_in = rd_q;
         STAT_END:  a_bus_in = 8'h0C;
         default:   a_bus_in = '0;
      endcase
   end

endmodule

// File: tb/tb_axi_control_unit.sv
// Directed bench for axi_control_unit: channel-side tag sequences with hand-computed bus/stream values.
module tb_axi_control_unit;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [7:0]  a_bus_out, a_bus_in;
   logic        a_operational_out, a_select_out, a_hold_out, a_address_out;
   logic        a_command_out, a_service_out, a_suppress_out;
   logic        a_select_in, a_operational_in, a_address_in, a_status_in, a_service_in, a_request_in;
   logic [15:0] cmd_tdata;
   logic        cmd_tvalid;
   logic [7:0]  send_tdata, recv_tdata;
   logic        send_tvalid, send_tlast, send_tready;
   logic        recv_tvalid, recv_tlast, recv_tready;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;
   logic saw_svc;

   localparam int ADR = 0, STA = 1, SVC = 2, SEL = 3, OPI = 4, RCV = 5, SRD = 6, CMV = 7;

   axi_control_unit #(.DEVICE_ADDRESS(8'h10), .ADDR_MASK(8'hF0)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .a_bus_out(a_bus_out), .a_bus_in(a_bus_in),
      .a_operational_out(a_operational_out), .a_select_out(a_select_out), .a_hold_out(a_hold_out),
      .a_address_out(a_address_out), .a_command_out(a_command_out), .a_service_out(a_service_out),
      .a_suppress_out(a_suppress_out),
      .a_select_in(a_select_in), .a_operational_in(a_operational_in), .a_address_in(a_address_in),
      .a_status_in(a_status_in), .a_service_in(a_service_in), .a_request_in(a_request_in),
      .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
      .send_tdata(send_tdata), .send_tvalid(send_tvalid), .send_tlast(send_tlast), .send_tready(send_tready),
      .recv_tdata(recv_tdata), .recv_tvalid(recv_tvalid), .recv_tlast(recv_tlast), .recv_tready(recv_tready),
      .busy(busy)
   );

   always #5 aclk = ~aclk;

   task automatic cyc(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic out_bit(input int idx);
      case (idx)
         ADR:     return a_address_in;
         STA:     return a_status_in;
         SVC:     return a_service_in;
         SEL:     return a_select_in;
         OPI:     return a_operational_in;
         RCV:     return recv_tvalid;
         SRD:     return send_tready;
         CMV:     return cmd_tvalid;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_out(input int idx, input logic val, input string tag);
      int n = 0;
      while (out_bit(idx) !== val && n < 40) begin
         cyc(1);
         n++;
      end
      chk(tag, 16'(out_bit(idx)), 16'(val));
   endtask

   task automatic present_addr(input logic [7:0] addr);
      a_bus_out = addr;
      a_address_out = 1'b1;
      cyc(4);
      a_select_out = 1'b1;
      a_hold_out = 1'b1;
   endtask

   task automatic addressed(input logic [7:0] echo, input logic [7:0] cmd, input logic [7:0] init_stat);
      wait_out(ADR, 1'b1, "address_in");
      chk("addr_echo", 16'(a_bus_in), 16'(echo));
      chk("busy_sel", 16'(busy), 16'd1);
      chk("sel_in_ours", 16'(a_select_in), 16'd0);
      a_address_out = 1'b0;
      a_bus_out = cmd;
      a_command_out = 1'b1;
      wait_out(CMV, 1'b1, "cmd_tvalid");
      chk("cmd_tdata", cmd_tdata, {echo, cmd});
      chk("addr_in_drop", 16'(a_address_in), 16'd0);
      cyc(1);
      chk("cmd_pulse", 16'(cmd_tvalid), 16'd0);
      a_command_out = 1'b0;
      a_bus_out = 8'h00;
      wait_out(STA, 1'b1, "init_status_in");
      chk("init_status", 16'(a_bus_in), 16'(init_stat));
      a_service_out = 1'b1;
      wait_out(STA, 1'b0, "init_accept");
      a_service_out = 1'b0;
   endtask

   task automatic end_status();
      wait_out(STA, 1'b1, "end_status_in");
      chk("end_status", 16'(a_bus_in), 16'h0C);
      a_service_out = 1'b1;
      wait_out(STA, 1'b0, "end_accept");
      a_service_out = 1'b0;
   endtask

   task automatic deselect();
      cyc(4);
      chk("desel_op_hold", 16'(a_operational_in), 16'd1);
      a_select_out = 1'b0;
      a_hold_out = 1'b0;
      wait_out(OPI, 1'b0, "desel_op_drop");
      chk("desel_tags", 16'({a_address_in, a_status_in, a_service_in, a_select_in}), 16'd0);
      chk("desel_bus", 16'(a_bus_in), 16'h00);
      chk("desel_busy", 16'(busy), 16'd0);
      cyc(4);
   endtask

   task automatic wr_byte(input logic [7:0] d);
      a_bus_out = d;
      a_service_out = 1'b1;
      wait_out(RCV, 1'b1, "recv_tvalid");
      chk("recv_tdata", 16'(recv_tdata), 16'(d));
      chk("recv_tlast", 16'(recv_tlast), 16'd0);
      cyc(2);
      chk("recv_hold", 16'(recv_tvalid), 16'd1);
      chk("wr_svc_hold", 16'(a_service_in), 16'd1);
      recv_tready = 1'b1;
      cyc(1);
      recv_tready = 1'b0;
      chk("recv_done", 16'(recv_tvalid), 16'd0);
      chk("wr_svc_drop", 16'(a_service_in), 16'd0);
      a_service_out = 1'b0;
      a_bus_out = 8'h00;
      wait_out(SVC, 1'b1, "wr_svc_again");
   endtask

   task automatic rd_byte(input logic [7:0] d, input logic l);
      send_tdata = d;
      send_tlast = l;
      send_tvalid = 1'b1;
      wait_out(SRD, 1'b1, "send_tready");
      cyc(1);
      chk("send_tready_once", 16'(send_tready), 16'd0);
      send_tvalid = 1'b0;
      send_tlast = 1'b0;
      chk("rd_svc", 16'(a_service_in), 16'd1);
      chk("rd_bus", 16'(a_bus_in), 16'(d));
      a_service_out = 1'b1;
      wait_out(SVC, 1'b0, "rd_svc_drop");
      a_service_out = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0;
      a_bus_out = 8'h00;
      {a_operational_out, a_select_out, a_hold_out, a_address_out} = '0;
      {a_command_out, a_service_out, a_suppress_out} = '0;
      send_tdata = 8'h00; send_tvalid = 1'b0; send_tlast = 1'b0;
      recv_tready = 1'b0;
      cyc(2);
      chk("rst_tags", 16'({a_select_in, a_operational_in, a_address_in, a_status_in,
                           a_service_in, a_request_in}), 16'd0);
      chk("rst_bus", 16'(a_bus_in), 16'h00);
      chk("rst_cmd", 16'({cmd_tvalid, send_tready, recv_tvalid, recv_tlast, busy}), 16'd0);
      chk("rst_data", {recv_tdata, 8'h00} | cmd_tdata, 16'h0000);
      aresetn = 1'b1;
      a_operational_out = 1'b1;
      cyc(4);

      // 1: foreign address, selection propagates
      present_addr(8'h22);
      wait_out(SEL, 1'b1, "nomatch_sel_in");
      chk("nomatch_op", 16'(a_operational_in), 16'd0);
      chk("nomatch_busy", 16'(busy), 16'd0);
      a_select_out = 1'b0; a_hold_out = 1'b0; a_address_out = 1'b0;
      wait_out(SEL, 1'b0, "nomatch_sel_drop");
      cyc(4);

      // 2: write command, two bytes, channel stop
      present_addr(8'h10);
      addressed(8'h10, 8'h01, 8'h00);
      wait_out(SVC, 1'b1, "wr_svc_first");
      wr_byte(8'hA5);
      wr_byte(8'h5A);
      a_command_out = 1'b1;
      wait_out(SVC, 1'b0, "wr_stop");
      a_command_out = 1'b0;
      end_status();
      deselect();

      // 3: read command, three bytes, tlast on the last
      present_addr(8'h10);
      addressed(8'h10, 8'h02, 8'h00);
      rd_byte(8'h11, 1'b0);
      rd_byte(8'h22, 1'b0);
      rd_byte(8'h33, 1'b1);
      end_status();
      deselect();

      // 4: Test I/O, status only
      present_addr(8'h10);
      addressed(8'h10, 8'h00, 8'h0C);
      saw_svc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         saw_svc |= a_service_in;
         cyc(1);
      end
      chk("testio_no_svc", 16'(saw_svc), 16'd0);
      deselect();

      // 5: selective reset with the send stream stalled
      present_addr(8'h10);
      addressed(8'h10, 8'h02, 8'h00);
      cyc(4);
      chk("stall_op", 16'(a_operational_in), 16'd1);
      chk("stall_tready", 16'(send_tready), 16'd0);
      a_operational_out = 1'b0;
      a_select_out = 1'b0;
      a_hold_out = 1'b0;
      cyc(3);
      chk("selrst_tags", 16'({a_operational_in, a_address_in, a_status_in, a_service_in, a_select_in}), 16'd0);
      chk("selrst_busy", 16'(busy), 16'd0);
      a_operational_out = 1'b1;
      cyc(4);
      present_addr(8'h10);
      addressed(8'h10, 8'h00, 8'h0C);
      deselect();

      // 6: address 13 with ADDR_MASK F0
      present_addr(8'h13);
`ifdef CU_ADDR_MASK_EN
      addressed(8'h13, 8'h02, 8'h00);
      rd_byte(8'h44, 1'b1);
      end_status();
      deselect();
`else
      wait_out(SEL, 1'b1, "exact_sel_in");
      chk("exact_op", 16'(a_operational_in), 16'd0);
      a_select_out = 1'b0; a_hold_out = 1'b0; a_address_out = 1'b0;
      wait_out(SEL, 1'b0, "exact_sel_drop");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
